// File: rtl/r_cpu_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the R-type datapath, with
// run/single-step control, a retired-instruction counter and halt-on-error.
module r_cpu_seq_ctrl #(
  parameter int CNT_W   = 16,
  parameter bit TRAP_OF = 1'b1
) (
  input  logic             clka,
  input  logic             rsta,
  input  logic             run,
  input  logic             step,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             ofa,
  input  logic             zfa,
  output logic             ir_we,
  output logic             ab_we,
  output logic             alu_we,
  output logic             reg_we,
  output logic             pc_we,
  output logic [2:0]       alu_op,
  output logic             busy,
  output logic             halted,
  output logic [1:0]       err,
  output logic             zf_q,
  output logic             of_q,
  output logic [CNT_W-1:0] inst_cnt,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t           state_q;
  logic [2:0]       alu_op_q;
  logic [1:0]       err_q;
  logic             zf_r_q;
  logic             of_r_q;
  logic [CNT_W-1:0] cnt_q;

  logic [2:0]       dec_op;
  logic             dec_legal;
  logic             is_addsub;

  always_comb begin
    dec_op    = 3'b000;
    dec_legal = 1'b0;
    if (op == 6'h00) begin
      dec_legal = 1'b1;
      case (func)
        6'h20:   dec_op = 3'b100;
        6'h22:   dec_op = 3'b101;
        6'h24:   dec_op = 3'b000;
        6'h25:   dec_op = 3'b001;
        6'h26:   dec_op = 3'b010;
        6'h27:   dec_op = 3'b011;
        6'h2A:   dec_op = 3'b110;
        6'h04:   dec_op = 3'b111;
        default: dec_legal = 1'b0;
      endcase
    end
  end

  // Only add/sub can trap on signed overflow; logic ops raise no overflow.
  assign is_addsub = (op == 6'h00) && ((func == 6'h20) || (func == 6'h22));

  always_ff @(posedge clka) begin
    if (rsta) begin
      state_q  <= S_IDLE;
      alu_op_q <= 3'b000;
      err_q    <= 2'd0;
      zf_r_q   <= 1'b0;
      of_r_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run || step) state_q <= S_FETCH;
        end
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          if (dec_legal) begin
            alu_op_q <= dec_op;
            state_q  <= S_EXEC;
          end else begin
            err_q   <= 2'd1;
            state_q <= S_HALT;
          end
        end
        S_EXEC: begin
          zf_r_q <= zfa;
          of_r_q <= ofa;
          if (TRAP_OF && ofa && is_addsub) begin
            err_q   <= 2'd2;
            state_q <= S_HALT;
          end else begin
            state_q <= S_WB;
          end
        end
        S_WB: begin
          cnt_q   <= cnt_q + 1'b1;
          state_q <= run ? S_FETCH : S_IDLE;
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The A/B latch is suppressed for an illegal word so nothing is captured.
  assign ir_we     = (state_q == S_FETCH);
  assign ab_we     = (state_q == S_DECODE) && dec_legal;
  assign alu_we    = (state_q == S_EXEC);
  assign reg_we    = (state_q == S_WB);
  assign pc_we     = (state_q == S_WB);
  assign busy      = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                     (state_q == S_EXEC)  || (state_q == S_WB);
  assign halted    = (state_q == S_HALT);
  assign alu_op    = alu_op_q;
  assign err       = err_q;
  assign zf_q      = zf_r_q;
  assign of_q      = of_r_q;
  assign inst_cnt  = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_r_cpu_seq_ctrl.sv
// Directed bench for r_cpu_seq_ctrl: a trapping 16-bit instance and a
// non-trapping 2-bit-counter instance share all inputs.
module tb_r_cpu_seq_ctrl;

  logic       clka = 1'b0;
  logic       rsta = 1'b1;
  logic       run  = 1'b0;
  logic       step = 1'b0;
  logic [5:0] op   = 6'h00;
  logic [5:0] func = 6'h20;
  logic       ofa  = 1'b0;
  logic       zfa  = 1'b0;

  logic        ir_we, ab_we, alu_we, reg_we, pc_we, busy, halted, zf_q, of_q;
  logic [2:0]  alu_op, dbg_state;
  logic [1:0]  err;
  logic [15:0] inst_cnt;

  logic        ir_we2, ab_we2, alu_we2, reg_we2, pc_we2, busy2, halted2, zf_q2, of_q2;
  logic [2:0]  alu_op2, dbg_state2;
  logic [1:0]  err2;
  logic [1:0]  inst_cnt2;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  always #5 clka = ~clka;

  r_cpu_seq_ctrl #(.CNT_W(16), .TRAP_OF(1'b1)) u_dut (
    .clka(clka), .rsta(rsta), .run(run), .step(step), .op(op), .func(func),
    .ofa(ofa), .zfa(zfa), .ir_we(ir_we), .ab_we(ab_we), .alu_we(alu_we),
    .reg_we(reg_we), .pc_we(pc_we), .alu_op(alu_op), .busy(busy),
    .halted(halted), .err(err), .zf_q(zf_q), .of_q(of_q),
    .inst_cnt(inst_cnt), .dbg_state(dbg_state)
  );

  r_cpu_seq_ctrl #(.CNT_W(2), .TRAP_OF(1'b0)) u_dut_nt (
    .clka(clka), .rsta(rsta), .run(run), .step(step), .op(op), .func(func),
    .ofa(ofa), .zfa(zfa), .ir_we(ir_we2), .ab_we(ab_we2), .alu_we(alu_we2),
    .reg_we(reg_we2), .pc_we(pc_we2), .alu_op(alu_op2), .busy(busy2),
    .halted(halted2), .err(err2), .zf_q(zf_q2), .of_q(of_q2),
    .inst_cnt(inst_cnt2), .dbg_state(dbg_state2)
  );

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packs {ir,ab,alu,reg,pc} so one comparison covers the whole strobe group.
  function automatic logic [4:0] strobes();
    return {ir_we, ab_we, alu_we, reg_we, pc_we};
  endfunction

  task automatic do_reset();
    rsta = 1'b1;
    tick();
    rsta = 1'b0;
  endtask

  logic [5:0] fv [3] = '{6'h22, 6'h24, 6'h2A};
  logic [2:0] ov [3] = '{3'b101, 3'b000, 3'b110};
  logic [5:0] ill_op [2] = '{6'h23, 6'h00};
  logic [5:0] ill_fn [2] = '{6'h20, 6'h08};

  initial begin
    // Reset
    tick();
    do_reset();
    chk("rst_strobes", 32'(strobes()), 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", err, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_cnt", inst_cnt, 0);
    chk("rst_zf_of", {zf_q, of_q}, 0);

    // Single step: add r3,r1,r2 (IR 00221820h), step pulse during DECODE ignored
    op = 6'h00; func = 6'h20; step = 1'b1;
    tick();
    step = 1'b0;
    chk("s1_fetch", 32'(strobes()), 5'b10000);
    chk("s1_busy", busy, 1);
    tick();
    chk("s1_decode", 32'(strobes()), 5'b01000);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("s1_exec", 32'(strobes()), 5'b00100);
    chk("s1_alu_op", alu_op, 3'b100);
    zfa = 1'b1;
    tick();
    zfa = 1'b0;
    chk("s1_wb", 32'(strobes()), 5'b00011);
    chk("s1_zf_q", zf_q, 1);
    chk("s1_alu_op_held", alu_op, 3'b100);
    tick();
    chk("s1_idle_busy", busy, 0);
    chk("s1_cnt", inst_cnt, 1);
    chk("s1_cnt_nt", inst_cnt2, 1);
    tick();
    tick();
    chk("s1_no_extra", busy, 0);
    chk("s1_no_extra_cnt", inst_cnt, 1);

    // Free run: sub, and, slt back to back; run dropped during the last EXEC
    run = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      func = fv[i];
      chk("run_fetch", 32'(strobes()), 5'b10000);
      tick();
      chk("run_decode", 32'(strobes()), 5'b01000);
      tick();
      chk("run_alu_op", alu_op, ov[i]);
      chk("run_exec_pc_we", pc_we, 0);
      if (i == 2) run = 1'b0;
      tick();
      chk("run_wb", 32'(strobes()), 5'b00011);
      tick();
      chk("run_cnt", inst_cnt, 2 + i);
      chk("run_cnt_nt", inst_cnt2, (2 + i) % 4);
    end
    chk("run_end_idle", busy, 0);
    chk("run_end_alu_op", alu_op, 3'b110);

    // run and step together enter FETCH once: or
    func = 6'h25; run = 1'b1; step = 1'b1;
    tick();
    run = 1'b0; step = 1'b0;
    chk("both_fetch", 32'(strobes()), 5'b10000);
    tick();
    tick();
    chk("both_alu_op", alu_op, 3'b001);
    tick();
    tick();
    tick();
    chk("both_single", busy, 0);
    chk("both_cnt", inst_cnt, 5);
    chk("both_cnt_nt", inst_cnt2, 1);

    // Overflow on add: trapping instance halts, non-trapping one retires
    func = 6'h20; step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    tick();
    chk("of_exec", 32'(strobes()), 5'b00100);
    ofa = 1'b1;
    tick();
    ofa = 1'b0;
    chk("of_halted", halted, 1);
    chk("of_err", err, 2);
    chk("of_of_q", of_q, 1);
    chk("of_strobes", 32'(strobes()), 0);
    chk("of_nt_wb", {reg_we2, pc_we2}, 2'b11);
    chk("of_nt_of_q", of_q2, 1);
    tick();
    chk("of_cnt", inst_cnt, 5);
    chk("of_cnt_nt", inst_cnt2, 2);
    step = 1'b1;
    tick();
    step = 1'b0; run = 1'b1;
    tick();
    tick();
    run = 1'b0;
    chk("of_hold_halted", halted, 1);
    chk("of_hold_busy", busy, 0);
    chk("of_hold_err", err, 2);

    // Reset during EXEC abandons the instruction: xor
    do_reset();
    func = 6'h26; step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    tick();
    chk("rx_exec_alu_op", alu_op, 3'b010);
    rsta = 1'b1;
    tick();
    rsta = 1'b0;
    chk("rx_strobes", 32'(strobes()), 0);
    chk("rx_outs", {busy, halted, err, alu_op}, 0);
    chk("rx_cnt", inst_cnt, 0);
    tick();
    chk("rx_no_reg_we", reg_we, 0);
    chk("rx_still_idle", busy, 0);

    // Illegal instructions: lw opcode, then unknown func
    for (int k = 0; k < 2; k++) begin
      do_reset();
      op = ill_op[k]; func = ill_fn[k]; step = 1'b1;
      tick();
      step = 1'b0;
      chk("ill_fetch", ir_we, 1);
      tick();
      chk("ill_decode_ab_we", ab_we, 0);
      tick();
      chk("ill_halted", halted, 1);
      chk("ill_err", err, 1);
      chk("ill_strobes", 32'(strobes()), 0);
      step = 1'b1; run = 1'b1;
      tick();
      step = 1'b0;
      tick();
      run = 1'b0;
      chk("ill_hold", {halted, busy, reg_we, pc_we}, 4'b1000);
      chk("ill_cnt", inst_cnt, 0);
    end
    do_reset();
    chk("ill_rst_clear", {halted, err}, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
